// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the RISC-V program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [31:0] PC_INC               = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory port plus the execute-datapath handshake of the sequencer.
interface pc_sequencer_if;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRData;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        Stall;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic        Halt;

  // master = sequencer, slave = memory/datapath side
  modport master (
    output IMemReq, IMemAddr, Instr, InstrValid,
    input  IMemAck, IMemRData, Stall, Branch, BranchTarget, Halt
  );
  modport slave (
    input  IMemReq, IMemAddr, Instr, InstrValid,
    output IMemAck, IMemRData, Stall, Branch, BranchTarget, Halt
  );
endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive un-acked fetch cycles; expired flags the TIMEOUT-th one.
module fetch_timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] MAX  = W'(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= '0;
    else if (enable && cnt != MAX)
      cnt <= cnt + 1'b1;
  end

  // Combinational so the FSM can leave FETCH on the same edge the count hits TIMEOUT.
  assign expired = (TIMEOUT != 0) && enable && (cnt == LAST);
endmodule

// File: rtl/pc_sequencer.sv
// Owns the PC and sequences fetch / execute / redirect / halt against a req-ack memory.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          TIMEOUT      = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  pc_sequencer_if.master bus,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] InstrCount,
  output logic        Misaligned,
  output logic        FetchErr,
  output logic        Halted
);
  state_t      state;
  logic [31:0] pc_q, instr_q, count_q;
  logic        req_q, valid_q, mis_q, err_q, halted_q;
  logic        to_en, to_clr, to_expired;

  assign to_en  = (state == FETCH) && !bus.IMemAck;
  assign to_clr = (state != FETCH) || bus.IMemAck;

  fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (CLK),
    .rst     (RST),
    .enable  (to_en),
    .clear   (to_clr),
    .expired (to_expired)
  );

  // Outputs are registered alongside the state so they are glitch-free.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      pc_q     <= RESET_VECTOR;
      instr_q  <= '0;
      count_q  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state <= FETCH;
            req_q <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.IMemAck) begin
            instr_q <= bus.IMemRData;
            state   <= EXEC;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end else if (to_expired) begin
            err_q    <= 1'b1;
            state    <= HALT;
            req_q    <= 1'b0;
            halted_q <= 1'b1;
          end
        end
        EXEC: begin
          if (bus.Halt) begin
            state    <= HALT;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end else if (bus.Stall) begin
            state <= EXEC;
          end else if (bus.Branch && bus.BranchTarget[1:0] != 2'b00) begin
            mis_q    <= 1'b1;
            state    <= HALT;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            pc_q    <= bus.Branch ? bus.BranchTarget : pc_q + PC_INC;
            count_q <= count_q + 32'd1;
            state   <= FETCH;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.IMemReq    = req_q;
  assign bus.IMemAddr   = pc_q;
  assign bus.Instr      = instr_q;
  assign bus.InstrValid = valid_q;
  assign PC             = pc_q;
  assign PCPlus4        = pc_q + PC_INC;
  assign InstrCount     = count_q;
  assign Misaligned     = mis_q;
  assign FetchErr       = err_q;
  assign Halted         = halted_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: vector table for the main flow plus hand sequences for corners.
module tb_pc_sequencer;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [31:0] pc0, pcp0, cnt0, pc1, pcp1, cnt1;
  logic        mis0, err0, hlt0, mis1, err1, hlt1;

  pc_sequencer_if if0();
  pc_sequencer_if if1();

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .TIMEOUT(15)) dut0 (
    .CLK(CLK), .RST(RST), .Start(start0), .bus(if0.master),
    .PC(pc0), .PCPlus4(pcp0), .InstrCount(cnt0),
    .Misaligned(mis0), .FetchErr(err0), .Halted(hlt0)
  );

  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC), .TIMEOUT(0)) dut1 (
    .CLK(CLK), .RST(RST), .Start(start1), .bus(if1.master),
    .PC(pc1), .PCPlus4(pcp1), .InstrCount(cnt1),
    .Misaligned(mis1), .FetchErr(err1), .Halted(hlt1)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        start, ack;
    logic [31:0] rdata;
    logic        stall, branch;
    logic [31:0] tgt;
    logic        halt;
    logic        req;
    logic        valid;
    logic [31:0] instr, pc, cnt;
    logic        mis, err, hlt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, a, input logic [31:0] rd, input logic st, br,
                              input logic [31:0] tg, input logic h, input logic rq, v,
                              input logic [31:0] ins, p, c, input logic m, e, hl);
    vec_t r;
    r.start = s; r.ack = a; r.rdata = rd; r.stall = st; r.branch = br; r.tgt = tg; r.halt = h;
    r.req = rq; r.valid = v; r.instr = ins; r.pc = p; r.cnt = c; r.mis = m; r.err = e; r.hlt = hl;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv0(input logic s, a, input logic [31:0] rd, input logic st, br,
                      input logic [31:0] tg, input logic h);
    start0 = s; if0.IMemAck = a; if0.IMemRData = rd; if0.Stall = st;
    if0.Branch = br; if0.BranchTarget = tg; if0.Halt = h;
  endtask

  task automatic drv1(input logic s, a, input logic [31:0] rd, input logic h);
    start1 = s; if1.IMemAck = a; if1.IMemRData = rd; if1.Stall = 1'b0;
    if1.Branch = 1'b0; if1.BranchTarget = 32'h0; if1.Halt = h;
  endtask

  task automatic rst_pulse();
    RST = 1'b1; tick(); RST = 1'b0;
  endtask

  localparam logic [31:0] A0 = 32'h0000_0013, A1 = 32'h0010_0093, A2 = 32'h0020_0113;
  localparam logic [31:0] A3 = 32'h0030_0193, A4 = 32'h0040_0213;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            s a rdata        st br tgt          h  rq v instr pc          cnt  m e hl
    tbl.push_back(mk(1,0,32'h0,      0,0,32'h0,       0, 1,0,32'h0, 32'h0,     32'd0,0,0,0));
    tbl.push_back(mk(0,1,A0,         0,0,32'h0,       0, 0,1,A0,    32'h0,     32'd0,0,0,0));
    tbl.push_back(mk(0,0,32'h0,      0,0,32'h0,       0, 1,0,A0,    32'h4,     32'd1,0,0,0));
    tbl.push_back(mk(0,1,A1,         0,0,32'h0,       0, 0,1,A1,    32'h4,     32'd1,0,0,0));
    tbl.push_back(mk(0,0,32'h0,      0,0,32'h0,       0, 1,0,A1,    32'h8,     32'd2,0,0,0));
    tbl.push_back(mk(0,1,A2,         0,0,32'h0,       0, 0,1,A2,    32'h8,     32'd2,0,0,0));
    tbl.push_back(mk(0,0,32'h0,      0,1,32'h100,     0, 1,0,A2,    32'h100,   32'd3,0,0,0));
    tbl.push_back(mk(0,1,A3,         0,0,32'h0,       0, 0,1,A3,    32'h100,   32'd3,0,0,0));
    tbl.push_back(mk(0,0,32'h0,      1,1,32'h200,     0, 0,1,A3,    32'h100,   32'd3,0,0,0));
    tbl.push_back(mk(0,0,32'h0,      1,1,32'h200,     0, 0,1,A3,    32'h100,   32'd3,0,0,0));
    tbl.push_back(mk(0,1,32'hDEAD,   1,1,32'h200,     0, 0,1,A3,    32'h100,   32'd3,0,0,0));
    tbl.push_back(mk(0,0,32'h0,      0,1,32'h40,      0, 1,0,A3,    32'h40,    32'd4,0,0,0));
    tbl.push_back(mk(0,0,32'h0,      0,0,32'h0,       0, 1,0,A3,    32'h40,    32'd4,0,0,0));
    tbl.push_back(mk(0,1,A4,         0,0,32'h0,       0, 0,1,A4,    32'h40,    32'd4,0,0,0));
    tbl.push_back(mk(0,0,32'h0,      0,1,32'h80,      1, 0,0,A4,    32'h40,    32'd4,0,0,1));
    tbl.push_back(mk(1,1,32'hBEEF,   0,0,32'h0,       0, 0,0,A4,    32'h40,    32'd4,0,0,1));

    drv0(0,0,0,0,0,0,0);
    drv1(0,0,0,0);
    RST = 1'b1;
    tick(); tick();
    chk("rst0 req", 32'(if0.IMemReq), 32'd0);
    chk("rst0 valid", 32'(if0.InstrValid), 32'd0);
    chk("rst0 pc", pc0, 32'h0);
    chk("rst0 instr", if0.Instr, 32'h0);
    chk("rst0 cnt", cnt0, 32'd0);
    chk("rst0 flags", {29'd0, mis0, err0, hlt0}, 32'd0);
    chk("rst1 pc", pc1, 32'hFFFF_FFFC);
    chk("rst1 pcplus4 wrap", pcp1, 32'h0);
    RST = 1'b0;

    // Main flow from the table
    for (int i = 0; i < tbl.size(); i++) begin
      drv0(tbl[i].start, tbl[i].ack, tbl[i].rdata, tbl[i].stall, tbl[i].branch,
           tbl[i].tgt, tbl[i].halt);
      tick();
      chk($sformatf("v%0d req", i), 32'(if0.IMemReq), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("v%0d addr", i), if0.IMemAddr, tbl[i].pc);
      chk($sformatf("v%0d valid", i), 32'(if0.InstrValid), 32'(tbl[i].valid));
      chk($sformatf("v%0d instr", i), if0.Instr, tbl[i].instr);
      chk($sformatf("v%0d pc", i), pc0, tbl[i].pc);
      chk($sformatf("v%0d pcplus4", i), pcp0, tbl[i].pc + 32'd4);
      chk($sformatf("v%0d cnt", i), cnt0, tbl[i].cnt);
      chk($sformatf("v%0d mis", i), 32'(mis0), 32'(tbl[i].mis));
      chk($sformatf("v%0d err", i), 32'(err0), 32'(tbl[i].err));
      chk($sformatf("v%0d halted", i), 32'(hlt0), 32'(tbl[i].hlt));
    end

    // Misaligned redirect at PC=8, first masked by a stall
    drv0(0,0,0,0,0,0,0);
    rst_pulse();
    drv0(1,0,0,0,0,0,0); tick();
    drv0(0,1,A0,0,0,0,0); tick();
    drv0(0,0,0,0,0,0,0); tick();
    drv0(0,1,A1,0,0,0,0); tick();
    drv0(0,0,0,0,0,0,0); tick();
    drv0(0,1,A2,0,0,0,0); tick();
    chk("mis pre pc", pc0, 32'h8);
    drv0(0,0,0,1,1,32'h102,0); tick();
    chk("mis stall mis", 32'(mis0), 32'd0);
    chk("mis stall valid", 32'(if0.InstrValid), 32'd1);
    drv0(0,0,0,0,1,32'h102,0); tick();
    chk("mis flag", 32'(mis0), 32'd1);
    chk("mis halted", 32'(hlt0), 32'd1);
    chk("mis pc", pc0, 32'h8);
    chk("mis cnt", cnt0, 32'd2);
    chk("mis req", 32'(if0.IMemReq), 32'd0);

    // Reset out of HALT, then out of FETCH
    drv0(0,0,0,0,0,0,0);
    RST = 1'b1; tick();
    chk("rsthalt mis", 32'(mis0), 32'd0);
    chk("rsthalt halted", 32'(hlt0), 32'd0);
    chk("rsthalt pc", pc0, 32'h0);
    chk("rsthalt cnt", cnt0, 32'd0);
    RST = 1'b0;
    drv0(1,0,0,0,0,0,0); tick();
    chk("rstfetch pre req", 32'(if0.IMemReq), 32'd1);
    drv0(0,0,0,0,0,0,0);
    RST = 1'b1; tick();
    chk("rstfetch req", 32'(if0.IMemReq), 32'd0);
    RST = 1'b0;

    // Timeout: 15 un-acked FETCH cycles trap
    drv0(1,0,0,0,0,0,0); tick();
    drv0(0,0,0,0,0,0,0);
    for (int i = 0; i < 14; i++) tick();
    chk("to14 err", 32'(err0), 32'd0);
    chk("to14 req", 32'(if0.IMemReq), 32'd1);
    tick();
    chk("to15 err", 32'(err0), 32'd1);
    chk("to15 halted", 32'(hlt0), 32'd1);
    chk("to15 req", 32'(if0.IMemReq), 32'd0);

    // Ack on the 14th cycle, then counter must restart from zero
    rst_pulse();
    drv0(1,0,0,0,0,0,0); tick();
    drv0(0,0,0,0,0,0,0);
    for (int i = 0; i < 13; i++) tick();
    drv0(0,1,A3,0,0,0,0); tick();
    chk("ack14 valid", 32'(if0.InstrValid), 32'd1);
    chk("ack14 instr", if0.Instr, A3);
    chk("ack14 err", 32'(err0), 32'd0);
    drv0(0,0,0,0,0,0,0); tick();
    for (int i = 0; i < 14; i++) tick();
    chk("reclr err", 32'(err0), 32'd0);
    chk("reclr addr", if0.IMemAddr, 32'h4);
    drv0(0,1,A4,0,0,0,0); tick();
    chk("reclr valid", 32'(if0.InstrValid), 32'd1);
    drv0(0,0,0,0,0,0,0);

    // dut1: wrap from 0xFFFF_FFFC, timeout disabled, halt, reset
    rst_pulse();
    drv1(0,1,32'h1234,0); tick();
    chk("idle ack req", 32'(if1.IMemReq), 32'd0);
    chk("idle ack instr", if1.Instr, 32'h0);
    drv1(1,0,0,0); tick();
    chk("w fetch addr", if1.IMemAddr, 32'hFFFF_FFFC);
    drv1(0,1,A0,0); tick();
    drv1(0,0,0,0); tick();
    chk("w addr", if1.IMemAddr, 32'h0);
    chk("w req", 32'(if1.IMemReq), 32'd1);
    chk("w cnt", cnt1, 32'd1);
    chk("w pcplus4", pcp1, 32'h4);
    for (int i = 0; i < 40; i++) tick();
    chk("noto err", 32'(err1), 32'd0);
    chk("noto req", 32'(if1.IMemReq), 32'd1);
    drv1(0,1,A1,0); tick();
    drv1(0,0,0,1); tick();
    chk("halt halted", 32'(hlt1), 32'd1);
    chk("halt cnt", cnt1, 32'd1);
    chk("halt pc", pc1, 32'h0);
    chk("halt valid", 32'(if1.InstrValid), 32'd0);
    drv1(1,1,A2,0); tick();
    chk("halt sticky", 32'(hlt1), 32'd1);
    chk("halt instr", if1.Instr, A1);
    drv1(0,0,0,0);
    RST = 1'b1; tick();
    chk("rst1b pc", pc1, 32'hFFFF_FFFC);
    chk("rst1b halted", 32'(hlt1), 32'd0);
    chk("rst1b cnt", cnt1, 32'd0);
    chk("rst1b req", 32'(if1.IMemReq), 32'd0);
    RST = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
